instruction_sequencer: RTL and testbench

Program-side counterpart of the instruction decoder: holds a small program memory, steps a program counter and drives the 8-bit `instruction_code` that the decoder consumes, one instruction per non-stalled cycle. It sits between the program-load interface (testbench or host) and the decoder. While idle or in reset it presents the `RST` opcode, so the downstream datapath is held in reset until a program is started.

---
 rtl/instruction_sequencer_pkg.sv | 24 ++
 rtl/instruction_sequencer_prog_mem.sv | 33 +++
 rtl/instruction_sequencer.sv | 106 ++++++++++
 tb/tb_instruction_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer slice.
// Holds the 4-bit opcode values seen by the decoder and the sequencer state
// encoding. RST/LD/ST are the existing decoder opcodes; HLT and NOP are
// sequencer-only codes that the ALU must never assign a meaning to.
package instruction_sequencer_pkg;

    localparam logic [3:0] OP_RST = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    // Build an instruction word from operand and opcode.
    function automatic logic [7:0] make_instr(input logic [3:0] operand, input logic [3:0] opcode);
        return {operand, opcode};
    endfunction

endpackage

// File: rtl/instruction_sequencer_prog_mem.sv
// Program memory for the instruction sequencer.
// DEPTH x 8 array, synchronous write, combinational read. Contents are not
// reset, so a program survives a sequencer reset.
// Ports:
//   clk    - write clock (rising edge)
//   we     - write strobe
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module instruction_sequencer_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: steps a program counter through a small program
// memory and issues one registered 8-bit instruction per non-stalled cycle
// to the instruction decoder.
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-high reset
//   prog_we          - program write strobe (accepted only when not running)
//   prog_addr        - program write address
//   prog_data        - program word, [3:0] opcode, [7:4] operand
//   start            - run request (pulse or level), restarts from address 0
//   stall            - freezes issue while high (RUN only)
//   instruction_code - registered instruction to the decoder
//   instr_valid      - instruction_code holds a fetched program word
//   pc               - address of the next word to fetch
//   busy             - state is RUN
//   halted           - state is HALT
//
// Flow control: there is no ready from the decoder; instead stall acts as an
// inverted ready. On an edge in RUN with stall=0 a new word is issued (or the
// HLT word is consumed); with stall=1, instruction_code, instr_valid and pc
// hold their values unchanged.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              start,
    input  logic              stall,
    output logic [7:0]        instruction_code,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    seq_state_t state;
    logic [7:0] fetch_word;
    logic       mem_we;

    // Writes are dropped while running so the program under execution
    // cannot change beneath the fetch pointer.
    assign mem_we = prog_we && (state != ST_RUN);

    instruction_sequencer_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (fetch_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            instruction_code <= make_instr(4'h0, OP_RST);
            instr_valid      <= 1'b0;
            pc               <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    // Output keeps presenting RST (idle) or NOP (halt) until
                    // the first fetch after the start edge.
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (fetch_word[3:0] == OP_HLT) begin
                            // HLT is consumed, never issued; pc stays on it.
                            state            <= ST_HALT;
                            instruction_code <= make_instr(4'h0, OP_NOP);
                            instr_valid      <= 1'b0;
                        end else begin
                            instruction_code <= fetch_word;
                            instr_valid      <= 1'b1;
                            // Power-of-two depth: natural overflow wraps to 0.
                            pc               <= pc + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    instruction_code <= make_instr(4'h0, OP_RST);
                    instr_valid      <= 1'b0;
                    pc               <= '0;
                end
            endcase
        end
    end

    assign busy   = (state == ST_RUN);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;

    logic              clk;
    logic              rst;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              start;
    logic              stall;
    logic [7:0]        instruction_code;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    // Observed bundle: {instruction_code, instr_valid, pc, busy, halted}
    logic [14:0] obs;
    logic [14:0] exp;
    int n_cmp;
    int n_fail;

    assign obs = {instruction_code, instr_valid, pc, busy, halted};

    // Hand-written expected words
    localparam logic [7:0] W_RST  = 8'h00;
    localparam logic [7:0] W_NOP  = 8'h0E;
    localparam logic [7:0] W_LD3  = 8'h31;
    localparam logic [7:0] W_ST2  = 8'h22;
    localparam logic [7:0] W_HLT  = 8'h0F;
    localparam logic [7:0] W_LD1  = 8'h11;

    instruction_sequencer #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .start            (start),
        .stall            (stall),
        .instruction_code (instruction_code),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .busy             (busy),
        .halted           (halted)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp = {W_RST, 1'b0, 4'd0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL reset_values: got %h want %h", obs, exp); n_fail++; end
        step();
        n_cmp++; if (obs !== exp) begin $display("FAIL idle_hold: got %h want %h", obs, exp); n_fail++; end
    endtask

    task automatic test_basic_run();
        write_word(4'd0, make_instr(4'h3, OP_LD));
        write_word(4'd1, make_instr(4'h2, OP_ST));
        write_word(4'd2, make_instr(4'h0, OP_HLT));
        pulse_start();
        exp = {W_RST, 1'b0, 4'd0, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL basic_e0: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_LD3, 1'b1, 4'd1, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL basic_e1: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_ST2, 1'b1, 4'd2, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL basic_e2: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_NOP, 1'b0, 4'd2, 1'b0, 1'b1};
        n_cmp++; if (obs !== exp) begin $display("FAIL basic_e3_halt: got %h want %h", obs, exp); n_fail++; end
        stall = 1'b1;
        step();
        stall = 1'b0;
        n_cmp++; if (obs !== exp) begin $display("FAIL halt_hold: got %h want %h", obs, exp); n_fail++; end
    endtask

    task automatic test_stall();
        pulse_start();
        exp = {W_NOP, 1'b0, 4'd0, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL stall_e0: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_LD3, 1'b1, 4'd1, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL stall_e1: got %h want %h", obs, exp); n_fail++; end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (obs !== exp) begin $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp); n_fail++; end
        end
        stall = 1'b0;
        step();
        exp = {W_ST2, 1'b1, 4'd2, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL stall_release: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_NOP, 1'b0, 4'd2, 1'b0, 1'b1};
        n_cmp++; if (obs !== exp) begin $display("FAIL stall_halt: got %h want %h", obs, exp); n_fail++; end
    endtask

    task automatic test_wrap();
        for (int a = 0; a < PROG_DEPTH; a++) begin
            write_word(ADDR_W'(a), make_instr(4'h1, OP_LD));
        end
        pulse_start();
        exp = {W_NOP, 1'b0, 4'd0, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL wrap_e0: got %h want %h", obs, exp); n_fail++; end
        for (int i = 0; i < 17; i++) begin
            step();
            exp = {W_LD1, 1'b1, 4'((i + 1) % 16), 1'b1, 1'b0};
            n_cmp++; if (obs !== exp) begin $display("FAIL wrap_step%0d: got %h want %h", i, obs, exp); n_fail++; end
        end
        // Leave the endless run with an asynchronous mid-cycle reset.
        rst = 1'b1;
        #1;
        exp = {W_RST, 1'b0, 4'd0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL wrap_async_reset: got %h want %h", obs, exp); n_fail++; end
        rst = 1'b0;
        step();
    endtask

    task automatic test_ignored_requests();
        write_word(4'd0, make_instr(4'h3, OP_LD));
        write_word(4'd1, make_instr(4'h2, OP_ST));
        write_word(4'd2, make_instr(4'h0, OP_HLT));
        pulse_start();
        exp = {W_RST, 1'b0, 4'd0, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL ign_e0: got %h want %h", obs, exp); n_fail++; end
        // Write and start during RUN: both must be dropped.
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = W_HLT;
        start     = 1'b1;
        step();
        prog_we = 1'b0;
        start   = 1'b0;
        exp = {W_LD3, 1'b1, 4'd1, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL ign_e1: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_ST2, 1'b1, 4'd2, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL ign_write_dropped: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_NOP, 1'b0, 4'd2, 1'b0, 1'b1};
        n_cmp++; if (obs !== exp) begin $display("FAIL ign_halt: got %h want %h", obs, exp); n_fail++; end
        // Same write plus start in HALT: both honoured together.
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = W_HLT;
        start     = 1'b1;
        step();
        prog_we = 1'b0;
        start   = 1'b0;
        exp = {W_NOP, 1'b0, 4'd0, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL simul_e0: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_LD3, 1'b1, 4'd1, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL simul_e1: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_NOP, 1'b0, 4'd1, 1'b0, 1'b1};
        n_cmp++; if (obs !== exp) begin $display("FAIL simul_halt_at1: got %h want %h", obs, exp); n_fail++; end
    endtask

    task automatic test_reset_mid_run();
        write_word(4'd1, make_instr(4'h2, OP_ST));
        pulse_start();
        step();
        exp = {W_LD3, 1'b1, 4'd1, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL rmr_e1: got %h want %h", obs, exp); n_fail++; end
        #2;
        rst = 1'b1;
        #1;
        exp = {W_RST, 1'b0, 4'd0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL rmr_async: got %h want %h", obs, exp); n_fail++; end
        step();
        n_cmp++; if (obs !== exp) begin $display("FAIL rmr_held: got %h want %h", obs, exp); n_fail++; end
        rst = 1'b0;
        pulse_start();
        step();
        exp = {W_LD3, 1'b1, 4'd1, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL rmr_restart_e1: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_ST2, 1'b1, 4'd2, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp) begin $display("FAIL rmr_restart_e2: got %h want %h", obs, exp); n_fail++; end
        step();
        exp = {W_NOP, 1'b0, 4'd2, 1'b0, 1'b1};
        n_cmp++; if (obs !== exp) begin $display("FAIL rmr_restart_halt: got %h want %h", obs, exp); n_fail++; end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        stall     = 1'b0;
        test_reset();
        test_basic_run();
        test_stall();
        test_wrap();
        test_ignored_requests();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
